// File: rtl/mult_share_sched.sv
// Round-robin sharing of one external W x W multiplier among NREQ requesters.
// Two stages: S1 registers the granted operands, S2 captures the product and tag.
module mult_share_sched #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      mult_x,
  output logic [W-1:0]      mult_y,
  input  logic [2*W-1:0]    mult_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*W-1:0]    res_o,
  output logic [TAGW-1:0]   res_tag,
  output logic              busy
);

  logic            s1_v_q, s1_v_d;
  logic [W-1:0]    s1_x_q, s1_x_d;
  logic [W-1:0]    s1_y_q, s1_y_d;
  logic [TAGW-1:0] s1_tag_q, s1_tag_d;
  logic            res_valid_q, res_valid_d;
  logic [2*W-1:0]  res_o_q, res_o_d;
  logic [TAGW-1:0] res_tag_q, res_tag_d;
  logic [TAGW-1:0] rr_ptr_q, rr_ptr_d;

  logic            adv1, adv2;
  logic            grant_found;
  logic [TAGW-1:0] grant_idx;
  logic            accept;

  function automatic logic [TAGW-1:0] wrap_idx(
    input int base,
    input int k
  );
    int s;
    s = base + k;
    if (s >= NREQ) s = s - NREQ;
    return TAGW'(s);
  endfunction

  assign adv2 = !res_valid_q || res_ready;
  assign adv1 = !s1_v_q || adv2;

  // Circular priority scan starting at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found &&
          req_valid[wrap_idx(int'(rr_ptr_q), k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(int'(rr_ptr_q), k);
      end
    end
  end

  // Gated by rst_n so no grant is visible while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && adv1 && grant_found)
      req_ready = NREQ'(1) << grant_idx;
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    s1_v_d      = s1_v_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_tag_d    = s1_tag_q;
    rr_ptr_d    = rr_ptr_q;
    res_valid_d = res_valid_q;
    res_o_d     = res_o_q;
    res_tag_d   = res_tag_q;
    if (accept) begin
      s1_v_d   = 1'b1;
      s1_x_d   = req_x[int'(grant_idx)*W +: W];
      s1_y_d   = req_y[int'(grant_idx)*W +: W];
      s1_tag_d = grant_idx;
      if (grant_idx == TAGW'(NREQ-1))
        rr_ptr_d = '0;
      else
        rr_ptr_d = grant_idx + TAGW'(1);
    end else if (adv2) begin
      s1_v_d = 1'b0;
    end
    if (adv2) begin
      res_valid_d = s1_v_q;
      if (s1_v_q) begin
        res_o_d   = mult_o;
        res_tag_d = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_tag_q    <= '0;
      rr_ptr_q    <= '0;
      res_valid_q <= 1'b0;
      res_o_q     <= '0;
      res_tag_q   <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_tag_q    <= s1_tag_d;
      rr_ptr_q    <= rr_ptr_d;
      res_valid_q <= res_valid_d;
      res_o_q     <= res_o_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign mult_x    = s1_x_q;
  assign mult_y    = s1_y_q;
  assign res_valid = res_valid_q;
  assign res_o     = res_o_q;
  assign res_tag   = res_tag_q;
  assign busy      = s1_v_q || res_valid_q;

endmodule
